user_id_enroller: RTL and testbench
===================================

Name: user_id_enroller

Overview:
- Write-side counterpart to the login ID matcher: collects a 4-digit user ID from the keypad and appends it to the shared user-ID RAM.
- The ID table format is the one the login path reads:
  - 4-bit nibbles, 4 nibbles per record, most significant digit at the lowest address.
  - The table ends with an all-F record (16'hFFFF).
- Sits beside the login controller on the same 32-nibble ID memory; the top-level grants it the port while Busy is high.

Parameters:
- ADDR_W, 5, nibble address width; table holds 2**ADDR_W/4 records.
- READ_LAT, 2, memory read latency in clocks (address registered to data valid).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- Enroll_Enter  in  1  one-cycle strobe; User_digit is valid on this cycle
- User_digit  in  4  keypad digit
- Cancel  in  1  abort digit entry
- mem_rdata  in  4  memory read data
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  4  memory write data (registered)
- mem_we  out  1  memory write enable (registered, one nibble per cycle)
- Busy  out  1  high from the 4th accepted digit until a result is reported
- Done  out  1  enrollment succeeded (level)
- Dup  out  1  ID already present (level)
- Full  out  1  no free record (level)
- NewID  out  ADDR_W  base address of the written record; valid while Done=1

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Digit count, shift register, scan base and state are cleared; state goes to DIGITS.
- DIGITS state:
  - Each Enroll_Enter shifts the digit in: UserID <= {UserID[11:0], User_digit}.
  - The first digit of an entry clears Done/Dup/Full/NewID.
  - On the 4th digit: scan base B=0, Busy=1, go to FETCH.
  - Cancel (takes priority over Enroll_Enter on the same cycle): clears the digit count and UserID, stays in DIGITS, leaves status bits untouched.
- Scan loop, FETCH -> WAIT (READ_LAT cycles) -> CATCH:
  - Reads nibbles B..B+3 in order.
  - CATCH shifts mem_rdata into RecID MSB-first.
  - After the 4th nibble go to COMPARE; otherwise return to FETCH with the address incremented.
- COMPARE:
  - RecID==UserID: Dup=1, go to REPORT.
  - Else RecID==16'hFFFF (terminator found at B):
    - B is the last record (B == 2**ADDR_W-4): Full=1, go to REPORT, no writes.
    - Otherwise go to WRTERM.
  - Else: B=B+4, clear RecID, go to FETCH.
  - Duplicate check precedes the terminator check. A UserID of FFFF therefore reports Dup.
- WRTERM: writes 4'hF to B+4..B+7, one nibble per cycle (mem_we=1 each cycle). The new terminator is written before the ID, so the table is never left unterminated.
- WRID: writes UserID[15:12], [11:8], [7:4], [3:0] to B, B+1, B+2, B+3 in that order.
- Result after WRID: Done=1, NewID=B, go to REPORT.
- REPORT:
  - Busy=0; go to DIGITS.
  - Result flags hold until the first digit of the next entry.
- Busy phase:
  - Cancel and Enroll_Enter are ignored from the 4th digit until REPORT (writes are atomic).
  - mem_we is 0 in every state except WRTERM and WRID.
- Address arithmetic is modulo 2**ADDR_W. The scan never wraps because the last record is always reached via the Full check.
- Latency to Done: empty table (terminator at 0) takes 4*(READ_LAT+2)+1+8 cycles after the 4th digit; each extra record scanned adds 4*(READ_LAT+2)+1 cycles.
- Reset during WRTERM/WRID:
  - Outputs clear immediately; the memory may hold a partial record.
  - Since the terminator is written first, the worst case is a record of partial digits followed by a valid terminator.

Optional Feature:
- Macro GUEST_PROTECT_EN.
- Defined:
  - UserID 16'h0000 is reserved for the guest login.
  - Entering 0000 sets Dup=1 directly after the 4th digit, with no memory access; Busy pulses for one cycle.
- Undefined: 0000 is treated like any other ID. A 0000 record present in the table gives Dup through the normal scan.

Test Plan:
- Memory {1234, FFFF, ...}; enter 5,6,7,8 -> F written at addrs 8-11, then 5,6,7,8 at addrs 4-7; Done=1, NewID=4, Dup=Full=0.
- Memory {1234, 5678, FFFF}; enter 5,6,7,8 -> Dup=1, no mem_we pulse, Busy drops in REPORT.
- Memory with 7 records and FFFF at base 28; enter 9,9,9,9 -> Full=1, no writes, NewID=0.
- Enter 1,2 then Cancel, then 3,4,5,6 -> enrolled ID is 3456, not 1234 or 1256.
- Assert rst low mid-WRID (after 2 ID nibbles) -> all outputs 0 on the same edge; memory reads {.., 3,4,x,x,F,F,F,F}.
- With GUEST_PROTECT_EN, enter 0,0,0,0 -> Dup=1 within 2 cycles, no memory reads or writes. Without it, on an empty table -> Done=1, NewID=0.

Source files
------------

// File: rtl/user_id_enroller.sv
// user_id_enroller: collects a 4-digit keypad ID and appends it to the shared nibble ID table.
// Optional macro GUEST_PROTECT_EN reserves ID 0000 (reported as Dup with no memory access).
module user_id_enroller #(
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Enroll_Enter,
  input  logic [3:0]        User_digit,
  input  logic              Cancel,
  input  logic [3:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata,
  output logic              mem_we,
  output logic              Busy,
  output logic              Done,
  output logic              Dup,
  output logic              Full,
  output logic [ADDR_W-1:0] NewID
);

  localparam int                LAT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0]  WAIT_LAST = LAT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((1 << ADDR_W) - 4);
  localparam logic [ADDR_W-1:0] REC_STEP  = ADDR_W'(4);

  typedef enum logic [2:0] {
    S_DIGITS,
    S_FETCH,
    S_WAIT,
    S_CATCH,
    S_COMPARE,
    S_WRTERM,
    S_WRID,
    S_REPORT
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        digit_cnt_q, digit_cnt_d;
  logic [1:0]        nib_q, nib_d;
  logic [LAT_W-1:0]  wait_q, wait_d;
  logic [15:0]       user_id_q, user_id_d;
  logic [15:0]       rec_id_q, rec_id_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dup_q, dup_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] new_id_q, new_id_d;
  logic [15:0]       shifted_id;

  assign shifted_id = {user_id_q[11:0], User_digit};

  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    nib_d       = nib_q;
    wait_d      = wait_q;
    user_id_d   = user_id_q;
    rec_id_d    = rec_id_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dup_d       = dup_q;
    full_d      = full_q;
    new_id_d    = new_id_q;

    case (state_q)
      S_DIGITS: begin
        if (Cancel) begin
          digit_cnt_d = '0;
          user_id_d   = '0;
        end else if (Enroll_Enter) begin
          user_id_d = shifted_id;
          if (digit_cnt_q == 2'd0) begin
            done_d   = 1'b0;
            dup_d    = 1'b0;
            full_d   = 1'b0;
            new_id_d = '0;
          end
          if (digit_cnt_q == 2'd3) begin
            digit_cnt_d = '0;
            busy_d      = 1'b1;
            base_d      = '0;
            nib_d       = '0;
            rec_id_d    = '0;
`ifdef GUEST_PROTECT_EN
            if (shifted_id == 16'h0000) begin
              dup_d   = 1'b1;
              state_d = S_REPORT;
            end else begin
              state_d = S_FETCH;
            end
`else
            state_d = S_FETCH;
`endif
          end else begin
            digit_cnt_d = digit_cnt_q + 2'd1;
          end
        end
      end

      S_FETCH: begin
        mem_addr_d = base_q + ADDR_W'(nib_q);
        wait_d     = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_CATCH;
        end else begin
          wait_d = wait_q + LAT_W'(1);
        end
      end

      S_CATCH: begin
        rec_id_d = {rec_id_q[11:0], mem_rdata};
        if (nib_q == 2'd3) begin
          nib_d   = '0;
          state_d = S_COMPARE;
        end else begin
          nib_d   = nib_q + 2'd1;
          state_d = S_FETCH;
        end
      end

      S_COMPARE: begin
        // Duplicate test first, so an ID of FFFF matches the terminator as Dup.
        if (rec_id_q == user_id_q) begin
          dup_d   = 1'b1;
          state_d = S_REPORT;
        end else if (rec_id_q == 16'hFFFF) begin
          if (base_q == LAST_BASE) begin
            full_d  = 1'b1;
            state_d = S_REPORT;
          end else begin
            // Write strobes are registered on entry so mem_we lines up with WRTERM/WRID.
            mem_addr_d  = base_q + REC_STEP;
            mem_wdata_d = 4'hF;
            mem_we_d    = 1'b1;
            nib_d       = '0;
            state_d     = S_WRTERM;
          end
        end else begin
          base_d   = base_q + REC_STEP;
          rec_id_d = '0;
          state_d  = S_FETCH;
        end
      end

      S_WRTERM: begin
        if (nib_q == 2'd3) begin
          nib_d       = '0;
          mem_addr_d  = base_q;
          mem_wdata_d = user_id_q[15:12];
          state_d     = S_WRID;
        end else begin
          nib_d      = nib_q + 2'd1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end

      S_WRID: begin
        if (nib_q == 2'd3) begin
          nib_d    = '0;
          mem_we_d = 1'b0;
          done_d   = 1'b1;
          new_id_d = base_q;
          state_d  = S_REPORT;
        end else begin
          nib_d      = nib_q + 2'd1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          case (nib_q)
            2'd0:    mem_wdata_d = user_id_q[11:8];
            2'd1:    mem_wdata_d = user_id_q[7:4];
            default: mem_wdata_d = user_id_q[3:0];
          endcase
        end
      end

      S_REPORT: begin
        busy_d  = 1'b0;
        state_d = S_DIGITS;
      end

      default: state_d = S_DIGITS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_DIGITS;
      digit_cnt_q <= '0;
      nib_q       <= '0;
      wait_q      <= '0;
      user_id_q   <= '0;
      rec_id_q    <= '0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dup_q       <= 1'b0;
      full_q      <= 1'b0;
      new_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      nib_q       <= nib_d;
      wait_q      <= wait_d;
      user_id_q   <= user_id_d;
      rec_id_q    <= rec_id_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dup_q       <= dup_d;
      full_q      <= full_d;
      new_id_q    <= new_id_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Dup       = dup_q;
  assign Full      = full_q;
  assign NewID     = new_id_q;

endmodule

// File: tb/tb_user_id_enroller.sv
// Bench for user_id_enroller: random ID tables and entries checked against a record-level table model.
module tb_user_id_enroller;

  localparam int AW   = 5;
  localparam int LAT  = 2;
  localparam int NNIB = 1 << AW;
  localparam int NREC = NNIB / 4;
  localparam int PER_REC = 4 * (LAT + 2) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Enroll_Enter = 1'b0;
  logic [3:0]    User_digit = '0;
  logic          Cancel = 1'b0;
  logic [3:0]    mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wdata;
  logic          mem_we;
  logic          Busy, Done, Dup, Full;
  logic [AW-1:0] NewID;

  logic [3:0]    mem [NNIB];
  logic [3:0]    img [NNIB];
  logic [3:0]    exp_mem [NNIB];
  logic [3:0]    pipe [LAT];
  logic          load = 1'b0;
  logic [AW-1:0] wr_a [$];
  logic [3:0]    wr_d [$];

  int total = 0;
  int bad   = 0;

  user_id_enroller #(.ADDR_W(AW), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .Enroll_Enter(Enroll_Enter), .User_digit(User_digit),
    .Cancel(Cancel), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .Busy(Busy), .Done(Done), .Dup(Dup), .Full(Full), .NewID(NewID)
  );

  always #5 clk = ~clk;

  // Nibble RAM with LAT clocks from registered address to valid data.
  assign mem_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (load) begin
      for (int i = 0; i < NNIB; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input int r, input logic [15:0] v);
    for (int k = 0; k < 4; k++) img[4*r+k] = v[15-4*k -: 4];
  endtask

  function automatic logic [15:0] get_rec(input int r);
    return {img[4*r], img[4*r+1], img[4*r+2], img[4*r+3]};
  endfunction

  function automatic logic [15:0] rand_id();
    logic [15:0] v;
    v = 16'($urandom);
    if (v == 16'hFFFF) v = 16'hFFFE;
    return v;
  endfunction

  task automatic gen_table(input int n);
    for (int r = 0; r < NREC; r++) begin
      if (r < n)       set_rec(r, rand_id());
      else if (r == n) set_rec(r, 16'hFFFF);
      else             set_rec(r, 16'($urandom));
    end
  endtask

  task automatic load_img();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    @(negedge clk); Enroll_Enter = 1'b1; User_digit = d;
    @(negedge clk); Enroll_Enter = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_done"}, 32'(Done), 0);
    check({tag, "_dup"}, 32'(Dup), 0);
    check({tag, "_full"}, 32'(Full), 0);
    check({tag, "_newid"}, 32'(NewID), 0);
  endtask

  // Loads img, enters (pre_n aborted digits, Cancel, then id), compares against the table model.
  task automatic run_enroll(input logic [15:0] id, input int pre_n, input logic [15:0] pre_val);
    int kind;
    int lat;
    int newid;
    int n;
    int wr_start;
    int mism;
    bit found;
    logic [AW-1:0] ea [$];
    logic [3:0]    ed [$];

    load_img();
    for (int i = 0; i < NNIB; i++) exp_mem[i] = img[i];
    wr_start = wr_a.size();

    kind = 0; lat = 0; newid = 0; found = 1'b0;
`ifdef GUEST_PROTECT_EN
    if (id == 16'h0000) begin
      kind = 1; lat = 0; found = 1'b1;
    end
`endif
    for (int r = 0; r < NREC && !found; r++) begin
      if (get_rec(r) == id) begin
        kind = 1; lat = (r + 1) * PER_REC; found = 1'b1;
      end else if (get_rec(r) == 16'hFFFF) begin
        found = 1'b1;
        if (r == NREC - 1) begin
          kind = 2; lat = NREC * PER_REC;
        end else begin
          kind = 0; lat = (r + 1) * PER_REC + 8; newid = 4 * r;
          for (int k = 0; k < 4; k++) begin
            ea.push_back(AW'(4*r + 4 + k)); ed.push_back(4'hF); exp_mem[4*r+4+k] = 4'hF;
          end
          for (int k = 0; k < 4; k++) begin
            ea.push_back(AW'(4*r + k)); ed.push_back(id[15-4*k -: 4]);
            exp_mem[4*r+k] = id[15-4*k -: 4];
          end
        end
      end
    end

    if (pre_n > 0) begin
      for (int i = 0; i < pre_n; i++) enter_digit(pre_val[15-4*i -: 4]);
      @(negedge clk);
      Cancel = 1'b1; Enroll_Enter = 1'($urandom); User_digit = 4'($urandom);
      @(negedge clk);
      Cancel = 1'b0; Enroll_Enter = 1'b0;
    end
    for (int i = 0; i < 4; i++) enter_digit(id[15-4*i -: 4]);

    check("busy_start", 32'(Busy), 1);
    n = 0;
    while (!(Done || Dup || Full) && n < 1000) begin
      Enroll_Enter = 1'($urandom); Cancel = ($urandom % 4) == 0; User_digit = 4'($urandom);
      @(negedge clk);
      n++;
    end
    Enroll_Enter = 1'b0; Cancel = 1'b0;

    check("latency", 32'(n), 32'(lat));
    check("busy_at_result", 32'(Busy), 1);
    check("done", 32'(Done), 32'(kind == 0));
    check("dup", 32'(Dup), 32'(kind == 1));
    check("full", 32'(Full), 32'(kind == 2));
    check("newid", 32'(NewID), 32'(newid));
    check("wr_count", 32'(wr_a.size() - wr_start), 32'(ea.size()));
    for (int i = 0; i < ea.size() && wr_start + i < wr_a.size(); i++)
      check("wr", {23'd0, wr_a[wr_start+i], wr_d[wr_start+i]}, {23'd0, ea[i], ed[i]});
    mism = 0;
    for (int i = 0; i < NNIB; i++) if (mem[i] !== exp_mem[i]) mism++;
    check("mem", 32'(mism), 0);
    @(negedge clk);
    check("busy_after", 32'(Busy), 0);
  endtask

  initial begin
    int n;
    int wr_start;
    int mism;
    logic [15:0] v;

    for (int i = 0; i < NNIB; i++) img[i] = 4'hF;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Append after one record.
    gen_table(1); set_rec(0, 16'h1234);
    run_enroll(16'h5678, 0, 16'h0);

    // Duplicate of the second record.
    gen_table(2); set_rec(0, 16'h1234); set_rec(1, 16'h5678);
    run_enroll(16'h5678, 0, 16'h0);

    // Terminator in the last record.
    gen_table(NREC - 1);
    for (int r = 0; r < NREC - 1; r++) if (get_rec(r) == 16'h9999) set_rec(r, 16'h9998);
    run_enroll(16'h9999, 0, 16'h0);

    // Aborted 1,2 then 3456 on an empty table.
    gen_table(0);
    run_enroll(16'h3456, 2, 16'h1200);

    // 0000 on an empty table.
    gen_table(0);
    run_enroll(16'h0000, 0, 16'h0);

    // Reset after two ID nibbles have been written.
    gen_table(0);
    load_img();
    for (int i = 0; i < NNIB; i++) exp_mem[i] = img[i];
    exp_mem[0] = 4'h3; exp_mem[1] = 4'h4;
    for (int i = 4; i < 8; i++) exp_mem[i] = 4'hF;
    wr_start = wr_a.size();
    enter_digit(4'h3); enter_digit(4'h4); enter_digit(4'h5); enter_digit(4'h6);
    n = 0;
    while (wr_a.size() - wr_start < 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rst_writes_seen", 32'(wr_a.size() - wr_start), 6);
    rst = 1'b0;
    #1;
    check_outputs_zero("midwrite_reset");
    @(negedge clk);
    mism = 0;
    for (int i = 0; i < NNIB; i++) if (mem[i] !== exp_mem[i]) mism++;
    check("rst_mem", 32'(mism), 0);
    rst = 1'b1;

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, NREC - 1);
      gen_table(n);
      case ($urandom % 6)
        0, 1:    v = (n > 0) ? get_rec($urandom_range(0, n - 1)) : rand_id();
        2:       v = 16'hFFFF;
        3:       v = 16'h0000;
        default: v = 16'($urandom);
      endcase
      if ($urandom % 3 == 0) run_enroll(v, $urandom_range(1, 3), 16'($urandom));
      else                   run_enroll(v, 0, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
